// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF, read-only) and memory-access (MEM) stages.
// One access at a time over a req/ack bus, with a MEM-streak starvation guard and a bus timeout.
module mem_port_arbiter #(
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   output logic        if_stall,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic        mem_stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   localparam int unsigned DW       = 32;
   localparam int unsigned SW       = $clog2(MAX_STREAK + 1);
   localparam int unsigned WW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q;
   logic            owner_mem_q;
   logic            bus_req_q;
   logic            bus_we_q;
   logic [DW-1:0]   bus_addr_q;
   logic [DW-1:0]   bus_wdata_q;
   logic [3:0]      bus_wstrb_q;
   logic [DW-1:0]   if_rdata_q;
   logic [DW-1:0]   mem_rdata_q;
   logic            if_done_q;
   logic            mem_done_q;
   logic            bus_err_q;
   logic [SW-1:0]   streak_q;
   logic [WW-1:0]   wait_q;

   logic grant_mem;
   logic grant_if;
   logic timeout_hit;

   // MEM wins unless IF has been passed over MAX_STREAK times in a row
   assign grant_mem   = mem_req & (~if_req | (streak_q < SW'(MAX_STREAK)));
   assign grant_if    = if_req & ~grant_mem;
   assign timeout_hit = (TIMEOUT != 0) && (wait_q == WW'(TMO_LAST));

   assign if_stall  = rst & if_req & ~if_done_q;
   assign mem_stall = rst & mem_req & ~mem_done_q;

   assign if_rdata  = if_rdata_q;
   assign if_done   = if_done_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_done  = mem_done_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_err   = bus_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_mem_q <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         streak_q    <= '0;
         wait_q      <= '0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         bus_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_mem || grant_if) begin
                  owner_mem_q <= grant_mem;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= grant_mem & mem_we;
                  bus_addr_q  <= grant_mem ? mem_addr : if_addr;
                  bus_wdata_q <= grant_mem ? mem_wdata : '0;
                  bus_wstrb_q <= (grant_mem && mem_we) ? mem_wstrb : 4'h0;
                  wait_q      <= '0;
                  if (grant_mem && if_req) begin
                     if (streak_q != SW'(MAX_STREAK)) streak_q <= streak_q + SW'(1);
                  end else begin
                     streak_q <= '0;
                  end
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               // an ack in the expiry cycle takes priority over the abort
               if (bus_ack) begin
                  bus_req_q <= 1'b0;
                  if (!bus_we_q) begin
                     if (owner_mem_q) mem_rdata_q <= bus_rdata;
                     else             if_rdata_q  <= bus_rdata;
                  end
                  if (owner_mem_q) mem_done_q <= 1'b1;
                  else             if_done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (timeout_hit) begin
                  bus_req_q <= 1'b0;
                  bus_err_q <= 1'b1;
                  if (owner_mem_q) begin
                     mem_rdata_q <= '0;
                     mem_done_q  <= 1'b1;
                  end else begin
                     if_rdata_q <= '0;
                     if_done_q  <= 1'b1;
                  end
                  state_q <= S_DONE;
               end else begin
                  wait_q <= wait_q + WW'(1);
               end
            end
            S_DONE: begin
               // requester still shows the finished access here, so no grant
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-timeline reference model with a
// bench-side memory, random ack delays, spurious acks, timeouts and a mid-access reset.
module tb_mem_port_arbiter;

   localparam int unsigned MAXS = 4;
   localparam int unsigned TMO  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // bench-side memory, word indexed by addr[6:2]
   logic [31:0] marr [32];

   // requester intent (what each stage is asking for right now)
   bit          ir_pend;
   logic [31:0] ir_addr;
   bit          mr_pend;
   bit          mr_we;
   logic [31:0] mr_addr;
   logic [31:0] mr_wdata;
   logic [3:0]  mr_wstrb;

   // timeline of the access in flight: bus busy from cycle s through e, done at e+1
   bit          acc;
   bit          acc_mem;
   bit          acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_wstrb;
   logic [31:0] acc_rdata;
   bit          aborted;
   int          s, e, delay, free_at;
   int          streak;
   int          mem_grants_seen, if_grants_seen, aborts_seen;
   logic [31:0] exp_if_rd, exp_mem_rd;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic sample_check();
      bit exp_req, done_c, exp_ifd, exp_md;
      exp_req = acc && (cyc >= s) && (e < 0 || cyc <= e);
      done_c  = acc && (e >= 0) && (cyc == e + 1);
      exp_ifd = done_c && !acc_mem;
      exp_md  = done_c && acc_mem;
      if (done_c) begin
         if (acc_mem) begin
            if (aborted)     exp_mem_rd = '0;
            else if (!acc_we) exp_mem_rd = acc_rdata;
         end else begin
            exp_if_rd = aborted ? 32'h0 : acc_rdata;
         end
      end
      check("bus_req",   32'(bus_req),   32'(exp_req));
      check("if_done",   32'(if_done),   32'(exp_ifd));
      check("mem_done",  32'(mem_done),  32'(exp_md));
      check("bus_err",   32'(bus_err),   32'(done_c && aborted));
      check("if_stall",  32'(if_stall),  32'(ir_pend && !exp_ifd));
      check("mem_stall", 32'(mem_stall), 32'(mr_pend && !exp_md));
      check("if_rdata",  if_rdata,  exp_if_rd);
      check("mem_rdata", mem_rdata, exp_mem_rd);
      if (exp_req) begin
         check("bus_addr",  bus_addr,         acc_addr);
         check("bus_we",    32'(bus_we),      32'(acc_we));
         check("bus_wstrb", 32'(bus_wstrb),   32'(acc_wstrb));
         if (acc_we) check("bus_wdata", bus_wdata, acc_wdata);
      end
      if (done_c) begin
         acc     = 1'b0;
         free_at = cyc + 1;
         if (acc_mem) mr_pend = 1'b0;
         else         ir_pend = 1'b0;
      end
   endtask

   task automatic drive();
      if (!ir_pend && $urandom_range(0, 99) < 50) begin
         ir_pend = 1'b1;
         ir_addr = 32'h0000_1000 | (32'($urandom_range(0, 31)) << 2);
      end
      if (!mr_pend && $urandom_range(0, 99) < 75) begin
         mr_pend  = 1'b1;
         mr_we    = ($urandom_range(0, 1) == 1);
         mr_addr  = 32'h0000_2000 | (32'($urandom_range(0, 31)) << 2);
         mr_wdata = $urandom;
         mr_wstrb = 4'($urandom_range(1, 15));
      end
      if_req    = ir_pend;
      if_addr   = ir_addr;
      mem_req   = mr_pend;
      mem_we    = mr_we;
      mem_addr  = mr_addr;
      mem_wdata = mr_wdata;
      mem_wstrb = mr_wstrb;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (acc && cyc >= s && e < 0) begin
         if (cyc - s == delay) begin
            bus_ack = 1'b1;
            if (acc_we) begin
               marr[acc_addr[6:2]] = merge(marr[acc_addr[6:2]], acc_wdata, acc_wstrb);
            end else begin
               bus_rdata = marr[acc_addr[6:2]];
               acc_rdata = bus_rdata;
            end
            e       = cyc;
            aborted = 1'b0;
         end else if (cyc - s == int'(TMO) - 1) begin
            e       = cyc;
            aborted = 1'b1;
            aborts_seen++;
         end
      end else if ($urandom_range(0, 99) < 15) begin
         bus_ack = 1'b1;
      end
   endtask

   // arbitration rule applied at the first free cycle with a pending request
   task automatic decide();
      int r;
      if (!acc && cyc >= free_at && (if_req || mem_req)) begin
         acc_mem = mem_req && (!if_req || streak < int'(MAXS));
         if (acc_mem) begin
            streak    = if_req ? streak + 1 : 0;
            acc_we    = mr_we;
            acc_addr  = mr_addr;
            acc_wdata = mr_wdata;
            acc_wstrb = mr_we ? mr_wstrb : 4'h0;
            mem_grants_seen++;
         end else begin
            streak    = 0;
            acc_we    = 1'b0;
            acc_addr  = ir_addr;
            acc_wdata = '0;
            acc_wstrb = 4'h0;
            if_grants_seen++;
         end
         acc = 1'b1;
         s   = cyc + 1;
         e   = -1;
         r   = $urandom_range(0, 19);
         if (r < 14)      delay = r % 4;
         else if (r < 17) delay = int'(TMO) - 1;
         else             delay = 1000;
      end
   endtask

   task automatic reset_mid_access();
      #2 rst = 1'b0;
      bus_ack = 1'b0;
      #1;
      check("rst_bus_req",   32'(bus_req),   32'h0);
      check("rst_if_done",   32'(if_done),   32'h0);
      check("rst_mem_done",  32'(mem_done),  32'h0);
      check("rst_if_stall",  32'(if_stall),  32'h0);
      check("rst_mem_stall", 32'(mem_stall), 32'h0);
      check("rst_if_rdata",  if_rdata,  32'h0);
      check("rst_mem_rdata", mem_rdata, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         cyc++;
      end
      rst        = 1'b1;
      acc        = 1'b0;
      streak     = 0;
      exp_if_rd  = '0;
      exp_mem_rd = '0;
      free_at    = cyc;
      decide();
   endtask

   initial begin
      bit did_rst;
      did_rst = 1'b0;
      for (int i = 0; i < 32; i++) marr[i] = $urandom;
      ir_pend = 1'b1;
      ir_addr = 32'h0000_0010;
      mr_pend = 1'b0;
      mr_we = 1'b0; mr_addr = '0; mr_wdata = '0; mr_wstrb = '0;
      if_req  = 1'b1;
      if_addr = ir_addr;
      acc = 1'b0; streak = 0; exp_if_rd = '0; exp_mem_rd = '0;
      mem_grants_seen = 0; if_grants_seen = 0; aborts_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      check("init_bus_req",  32'(bus_req),  32'h0);
      check("init_if_done",  32'(if_done),  32'h0);
      check("init_mem_done", 32'(mem_done), 32'h0);
      check("init_if_stall", 32'(if_stall), 32'h0);
      check("init_bus_err",  32'(bus_err),  32'h0);
      check("init_if_rdata", if_rdata, 32'h0);
      rst     = 1'b1;
      cyc     = 0;
      free_at = 0;
      decide();
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk); #1;
         cyc++;
         sample_check();
         drive();
         decide();
         if (!did_rst && cyc > 2000 && acc && cyc >= s && (e < 0 || cyc <= e)) begin
            did_rst = 1'b1;
            reset_mid_access();
         end
      end
      check("saw_mem_grants", 32'(mem_grants_seen > 50), 32'h1);
      check("saw_if_grants",  32'(if_grants_seen > 50),  32'h1);
      check("saw_aborts",     32'(aborts_seen > 0),      32'h1);
      check("saw_reset",      32'(did_rst),              32'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
